// File: rtl/uart_rx_if.sv
// Byte-side handshake between the UART receiver and its consumer.
// The master side produces bytes and error pulses; the slave side returns ready.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frm_err;
  logic       overrun;

  modport master (
    output rx_data, rx_valid, frm_err, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frm_err, overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_deser.sv
// 8N1 UART receiver: 2-flop synchroniser, oversampled mid-bit sampling,
// byte delivered on a valid/ready interface with framing-error and overrun pulses.
//
// state     | meaning
// IDLE      | line idle, waiting for a falling edge on rxs
// START     | timing to the middle of the start bit, glitch check
// DATA      | sampling 8 data bits at mid-bit, LSB first
// STOP      | sampling the stop bit, deliver or flag framing error
// WAIT_IDLE | after a framing error, wait for the line to return high
module uart_rx_deser #(
  parameter int CLOCK_RATE = 100_000_000,
  parameter int BAUD_RATE  = 9_600,
  parameter int OVERSAMPLE = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      rxd,
  uart_rx_if.master rx
);

  localparam int DIV   = (CLOCK_RATE + BAUD_RATE * OVERSAMPLE / 2) / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic             rx_meta, rxs;
  logic [DIV_W-1:0] div_cnt;
  logic [OS_W-1:0]  os_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;

  logic run, tick, mid_start, mid_bit;
  logic shift_en, deliver, frame_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    run       = (state == START) || (state == DATA) || (state == STOP);
    tick      = run && (div_cnt == DIV_LAST);
    mid_start = (state == START) && tick && (os_cnt == OS_MID);
    mid_bit   = tick && (os_cnt == OS_LAST);
    shift_en  = 1'b0;
    deliver   = 1'b0;
    frame_bad = 1'b0;
    case (state)
      IDLE:      if (!rxs) state_nxt = START;
      START:     if (mid_start) state_nxt = rxs ? IDLE : DATA;
      DATA: begin
        if (mid_bit) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (mid_bit) begin
          if (rxs) begin
            deliver   = 1'b1;
            state_nxt = IDLE;
          end else begin
            frame_bad = 1'b1;
            state_nxt = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: if (rxs) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Divider and sub-bit counter only run while a frame is in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      os_cnt  <= '0;
      bit_cnt <= 3'd0;
      shift   <= 8'h00;
    end else begin
      if (!run || tick) div_cnt <= '0;
      else              div_cnt <= div_cnt + 1'b1;

      if (!run || mid_start)  os_cnt <= '0;
      else if (tick)          os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;

      if (mid_start)     bit_cnt <= 3'd0;
      else if (shift_en) bit_cnt <= bit_cnt + 3'd1;

      if (shift_en) shift <= {rxs, shift[7:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx.rx_data  <= 8'h00;
      rx.rx_valid <= 1'b0;
      rx.frm_err  <= 1'b0;
      rx.overrun  <= 1'b0;
    end else begin
      rx.frm_err <= frame_bad;
      rx.overrun <= 1'b0;
      if (deliver) begin
        // A byte consumed on this same edge frees the slot for the new one.
        if (!rx.rx_valid || rx.rx_ready) begin
          rx.rx_data  <= shift;
          rx.rx_valid <= 1'b1;
        end else begin
          rx.overrun <= 1'b1;
        end
      end else if (rx.rx_valid && rx.rx_ready) begin
        rx.rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_deser.md
Name: uart_rx_deser

Overview:
- Synthesizable UART receiver, 8N1, LSB first. Directly downstream of the behavioural serial driver used in the benches, and of the physical RS232 pin in silicon.
- Synchronises the asynchronous serial line and recovers bit timing with an oversampling baud tick.
- Deserialises each frame and presents the byte on a valid/ready interface to the command parser.
- Reports framing errors and overruns.

Parameters:
- CLOCK_RATE, 100_000_000: system clock frequency in Hz.
- BAUD_RATE, 9_600: serial bit rate in bits/s. Matches the serial driver default.
- OVERSAMPLE, 16: baud ticks per bit. Must be even and at least 4.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rxd  input  1  asynchronous serial line. Idle state is 1.
- rx_data  output  8  received byte. Valid while rx_valid=1.
- rx_valid  output  1  byte available. Held until consumed.
- rx_ready  input  1  consumer accepts the byte when rx_valid=1 and rx_ready=1 on a rising edge.
- frm_err  output  1  one-cycle pulse when the stop bit is sampled as 0.
- overrun  output  1  one-cycle pulse when a completed byte is dropped.

Behaviour:
- Reset (async assert, synchronous release): all outputs 0, except rx_data = 8'h00. Synchroniser flops = 1. FSM = IDLE. All counters = 0.
- Synchroniser: 2-flop on rxd. All logic uses the synchronised value rxs, which lags rxd by 2 cycles.
- Baud tick generator:
  - DIV = (CLOCK_RATE + BAUD_RATE*OVERSAMPLE/2) / (BAUD_RATE*OVERSAMPLE), rounded.
  - The divider counts 0..DIV-1 and emits a one-cycle tick at DIV-1.
  - It is held at 0 in IDLE and WAIT_IDLE.
  - The sub-bit counter os_cnt counts ticks 0..OVERSAMPLE-1.
- FSM states:
  - IDLE: rxs==0 -> START. Clear the divider and os_cnt.
  - START: on the tick where os_cnt reaches OVERSAMPLE/2-1 (mid start bit), sample rxs.
    - rxs==0 -> DATA; clear os_cnt and bit_cnt.
    - rxs==1 -> IDLE. This is glitch rejection: no outputs.
  - DATA: on each tick where os_cnt reaches OVERSAMPLE-1 (mid bit), shift rxs into shift[7] and shift right, so the LSB arrives first. Increment bit_cnt. After the 8th bit -> STOP.
  - STOP: on the tick where os_cnt reaches OVERSAMPLE-1, sample rxs.
    - rxs==1 -> deliver the byte (see handshake) -> IDLE.
    - rxs==0 -> pulse frm_err for 1 cycle, discard the byte -> WAIT_IDLE.
  - WAIT_IDLE: stay until rxs==1 (break / stuck-low line), then -> IDLE. No new start is detected while here.
- Output handshake, on the cycle the byte is delivered:
  - rx_valid==0: rx_data <= shift; rx_valid <= 1 on the next edge. Latency is 1 cycle after the stop-bit sample tick.
  - rx_valid==1 and rx_ready==1 on the same cycle: the old byte is consumed, the new byte is loaded, rx_valid stays 1, no overrun.
  - rx_valid==1 and rx_ready==0: the new byte is dropped, rx_data is unchanged, overrun pulses for 1 cycle.
  - rx_valid && rx_ready at any other time: rx_valid <= 0. rx_data holds its last value.
- frm_err and overrun never assert together, since they come from different stop-bit outcomes.
- Reset mid-frame aborts immediately: FSM -> IDLE, rx_valid -> 0. The remainder of the frame after release may be misinterpreted. Benches resynchronise on a full idle bit time.
- Timing tolerance: sampling at mid-bit with OVERSAMPLE=16 tolerates about ±4% total baud mismatch across a frame.
- No combinational path from rxd or rx_ready to any output. All outputs are registered.

Test Plan:
- Nominal byte (CLOCK_RATE=16_000_000, BAUD_RATE=1_000_000 so DIV=1; driver bit period 1000 ns): send 8'hA5 -> single rx_valid rise about 9.5 bit periods after the start edge, rx_data=8'hA5, frm_err=0, overrun=0.
- Back-to-back with rx_ready=1 held: send 8'h00, 8'hFF, 8'h3C with no idle gap -> three accepted bytes in order, no errors.
- Glitch rejection: drive rxd low for 300 ns then high -> no rx_valid, FSM back in IDLE. A following 8'h55 is received correctly.
- Framing error: send start, data 8'h81, stop bit = 0, then hold low 3 bit periods -> frm_err pulses once, rx_valid stays 0. A subsequent 8'h42 is received after the line returns high.
- Overrun: rx_ready=0, send 8'h11 then 8'h22 -> rx_valid=1 with rx_data=8'h11, one overrun pulse at the second stop-bit sample. Raise rx_ready -> rx_valid falls, rx_data remains 8'h11.
- Reset mid-frame: assert rst_n=0 during bit 4 of 8'hC3 -> outputs cleared immediately. After release plus 2 idle bit periods, 8'h7E is received correctly.
